booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier: the generalised successor to the team's fixed 8-bit signed multiplier. It multiplies two WIDTH-bit operands, signed or unsigned (selected per operation), one Booth step per clock. It has an explicit start/busy/done handshake and a held result register. It sits in the datapath as a shared multi-cycle arithmetic unit driven by a controller FSM.

---
 rtl/booth_mult_seq.sv | 132 +++++++++++++
 tb/tb_booth_mult_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Sequential radix-2 Booth multiplier. Signed or unsigned
//               WIDTH x WIDTH -> 2*WIDTH product, one Booth step per clock,
//               start/busy/done handshake, result held until next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tc,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] OUT
);

    // One extra bit lets unsigned operands with MSB=1 be treated as
    // positive numbers by the signed Booth recoding.
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    localparam logic [CW-1:0] C_CNT_INIT = CW'(E);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state_q;
    logic [0:0]         w_state_d;
    logic [E-1:0]       r_acc_q;
    logic [E-1:0]       r_mreg_q;
    logic [E-1:0]       r_qreg_q;
    logic               r_q0_q;
    logic [CW-1:0]      r_cnt_q;
    logic [2*WIDTH-1:0] r_out_q;
    logic               r_done_q;

    logic               w_capture;
    logic               w_last;
    logic [E-1:0]       w_m_ext;
    logic [E-1:0]       w_q_ext;
    logic [E-1:0]       w_sum;
    logic [E-1:0]       w_acc_sh;
    logic [E-1:0]       w_qreg_sh;

    assign w_capture = (r_state_q == S_IDLE) && start;
    assign w_last    = (r_cnt_q == C_CNT_LAST);
    assign w_m_ext   = tc ? {m[WIDTH-1], m} : {1'b0, m};
    assign w_q_ext   = tc ? {q[WIDTH-1], q} : {1'b0, q};

    // Booth recoding of {Qreg[0], guard}: 10 subtracts, 01 adds, else hold.
    always_comb begin
        w_sum = r_acc_q;
        case ({r_qreg_q[0], r_q0_q})
            2'b10:   w_sum = r_acc_q - r_mreg_q;
            2'b01:   w_sum = r_acc_q + r_mreg_q;
            default: w_sum = r_acc_q;
        endcase
    end

    // Arithmetic right shift of {A, Qreg}; the bit leaving Qreg becomes the guard.
    assign w_acc_sh  = {w_sum[E-1], w_sum[E-1:1]};
    assign w_qreg_sh = {w_sum[0], r_qreg_q[E-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic: run for exactly E steps after a capture.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (start)  w_state_d = S_RUN;
            S_RUN:   if (w_last) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Outputs derived from state and the held result/done registers.
    always_comb begin
        busy = (r_state_q == S_RUN);
        done = r_done_q;
        OUT  = r_out_q;
    end

    // Datapath: operand capture, Booth steps, result write on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q  <= '0;
            r_mreg_q <= '0;
            r_qreg_q <= '0;
            r_q0_q   <= 1'b0;
            r_cnt_q  <= '0;
            r_out_q  <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= 1'b0;
            if (w_capture) begin
                r_acc_q  <= '0;
                r_q0_q   <= 1'b0;
                r_mreg_q <= w_m_ext;
                r_qreg_q <= w_q_ext;
                r_cnt_q  <= C_CNT_INIT;
            end else if (r_state_q == S_RUN) begin
                r_acc_q  <= w_acc_sh;
                r_qreg_q <= w_qreg_sh;
                r_q0_q   <= r_qreg_q[0];
                r_cnt_q  <= r_cnt_q - C_CNT_ONE;
                if (w_last) begin
                    // The top two bits of the 2E-bit product are pure sign
                    // extension, so dropping them is lossless.
                    r_out_q  <= {w_acc_sh[E-3:0], w_qreg_sh};
                    r_done_q <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_seq
// Description : Self-checking bench for booth_mult_seq at WIDTH=8 and 13.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;

    logic        start8, tc8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] out8;

    logic        start13, tc13, busy13, done13;
    logic [12:0] m13, q13;
    logic [25:0] out13;

    int checks = 0;
    int errors = 0;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .tc(tc8), .m(m8), .q(q8),
        .busy(busy8), .done(done8), .OUT(out8)
    );

    booth_mult_seq #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst), .start(start13), .tc(tc13), .m(m13), .q(q13),
        .busy(busy13), .done(done13), .OUT(out13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          tc;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers and multiply exactly.
    function automatic logic [63:0] ref_prod(input int w, input bit t,
                                             input logic [31:0] mv, input logic [31:0] qv);
        longint a, b, p;
        logic [63:0] mask;
        mask = (64'(1) << w) - 64'(1);
        a = longint'(64'(mv) & mask);
        b = longint'(64'(qv) & mask);
        if (t && mv[w-1]) a = a - (longint'(1) << w);
        if (t && qv[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 64'(p) & ((64'(1) << (2*w)) - 64'(1));
    endfunction

    function automatic logic sel_done(input int w);
        return (w == 8) ? done8 : done13;
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 8) ? busy8 : busy13;
    endfunction

    function automatic logic [63:0] sel_out(input int w);
        return (w == 8) ? 64'(out8) : 64'(out13);
    endfunction

    task automatic drive(input int w, input bit s, input bit t,
                         input logic [31:0] mv, input logic [31:0] qv);
        if (w == 8) begin
            start8 = s; tc8 = t; m8 = mv[7:0]; q8 = qv[7:0];
        end else begin
            start13 = s; tc13 = t; m13 = mv[12:0]; q13 = qv[12:0];
        end
    endtask

    // One full operation; lat = edges from start capture to done visible (-1 on timeout).
    task automatic run_op(input int w, input bit t, input logic [31:0] mv, input logic [31:0] qv,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        drive(w, 1'b1, t, mv, qv);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, t, ~mv, ~qv);
        chk("busy_after_start", 64'(sel_busy(w)), 64'd1);
        lat = -1;
        for (int k = 1; k <= w + 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel_done(w)) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout: got no done expected done within %0d", w + 10);
        res = sel_out(w);
        chk("busy_low_at_done", 64'(sel_busy(w)), 64'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [63:0] res;
        logic [63:0] held;
        int          lat;
        int          d1, d2;
        bit          seen;
        logic [31:0] mv, qv;
        bit          t;

        vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[4] = '{1'b1, 8'hFF, 8'h02, 16'hFFFE};
        vecs[5] = '{1'b1, 8'h00, 8'hB3, 16'h0000};

        rst = 1'b1;
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(13, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy8", 64'(busy8), 64'd0);
        chk("reset_done8", 64'(done8), 64'd0);
        chk("reset_out8", 64'(out8), 64'd0);
        chk("reset_busy13", 64'(busy13), 64'd0);
        chk("reset_done13", 64'(done13), 64'd0);
        chk("reset_out13", 64'(out13), 64'd0);

        // Directed corner vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(8, vecs[i].tc, 32'(vecs[i].m), 32'(vecs[i].q), res, lat);
            chk($sformatf("vec%0d_out", i), res, 64'(vecs[i].exp));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd9);
        end

        // Result holds between operations.
        run_op(8, 1'b1, 32'hFF, 32'h02, res, lat);
        repeat (4) @(negedge clk);
        chk("out_hold", 64'(out8), 64'hFFFE);
        chk("done_single_pulse", 64'(done8), 64'd0);

        // Start while busy is ignored.
        @(negedge clk); drive(8, 1'b1, 1'b0, 32'd3, 32'd5);
        @(posedge clk);                                         // T0
        @(negedge clk); drive(8, 1'b0, 1'b0, 32'd3, 32'd5);
        @(posedge clk);                                         // T1
        @(negedge clk);
        @(posedge clk);                                         // T2
        @(negedge clk); drive(8, 1'b1, 1'b0, 32'd7, 32'd9);
        @(posedge clk);                                         // T3
        @(negedge clk); drive(8, 1'b0, 1'b0, 32'd7, 32'd9);
        chk("ignore_busy", 64'(busy8), 64'd1);
        lat = -1;
        for (int k = 4; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin lat = k; break; end
        end
        chk("ignore_lat", 64'(lat), 64'd9);
        chk("ignore_out", 64'(out8), 64'd15);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        chk("ignore_no_restart", 64'(seen), 64'd0);

        // Start held high through done: back-to-back issue.
        @(negedge clk); drive(8, 1'b1, 1'b0, 32'd10, 32'd11);
        @(posedge clk);                                         // T0
        @(negedge clk); drive(8, 1'b1, 1'b0, 32'd12, 32'd13);
        d1 = -1; d2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_out1", 64'(out8), 64'd110);
                end else begin
                    d2 = k;
                    chk("b2b_out2", 64'(out8), 64'd156);
                    start8 = 1'b0;
                    break;
                end
            end
        end
        start8 = 1'b0;
        chk("b2b_lat1", 64'(d1), 64'd9);
        chk("b2b_gap", 64'(d2 - d1), 64'd10);

        // Reset mid-run discards the operation.
        @(negedge clk); drive(8, 1'b1, 1'b1, 32'd20, 32'd30);
        @(posedge clk);                                         // T0
        @(negedge clk); drive(8, 1'b0, 1'b1, 32'd20, 32'd30);
        repeat (3) begin @(posedge clk); @(negedge clk); end   // T1..T3
        rst = 1'b1;
        @(posedge clk);                                         // T4
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_out", 64'(out8), 64'd0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);
        run_op(8, 1'b1, 32'hFB, 32'd7, res, lat);
        chk("after_rst_out", res, 64'hFFDD);
        chk("after_rst_lat", 64'(lat), 64'd9);

        // Reset and start on the same edge: reset wins.
        held = 64'(out8);
        @(negedge clk); rst = 1'b1; drive(8, 1'b1, 1'b0, 32'd2, 32'd2);
        @(posedge clk);
        @(negedge clk); rst = 1'b0; start8 = 1'b0;
        chk("rst_start_busy", 64'(busy8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_start_busy2", 64'(busy8 | done8), 64'd0);
        chk("rst_start_out", 64'(out8), 64'd0);
        if (held == 64'd0) $display("note: held value was zero before reset");

        // Randomised operands against the reference model, both widths.
        foreach (vecs[i]) begin end
        for (int w = 8; w <= 13; w += 5) begin
            for (int i = 0; i < 700; i++) begin
                mv = $urandom;
                qv = $urandom;
                t  = 1'($urandom_range(0, 1));
                if (i % 16 == 0) mv = 32'(1) << (w - 1);
                if (i % 16 == 1) qv = 32'hFFFF_FFFF;
                run_op(w, t, mv, qv, res, lat);
                chk($sformatf("rand_w%0d_out", w), res, ref_prod(w, t, mv, qv));
                chk($sformatf("rand_w%0d_lat", w), 64'(lat), 64'(w + 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
